// File: rtl/sweep_pkg.sv
// sweep_pkg: state encoding and direction constants shared by the sweep controller and counter
package sweep_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        UP       = 3'd1,
        HOLD_TOP = 3'd2,
        DOWN     = 3'd3,
        HOLD_BOT = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic logic is_busy(state_t s);
        return (s == UP) || (s == HOLD_TOP) || (s == DOWN) || (s == HOLD_BOT);
    endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// sweep_hold_timer: counts dwell cycles at a limit and flags the last one
module sweep_hold_timer #(
    parameter int HOLD_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic [HW-1:0] hold_cnt;

    assign expired = run && (hold_cnt == HW'(HOLD_CYCLES - 1));

    // dwell counter: cleared outside hold states, wraps to zero on the last dwell cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold_cnt <= '0;
        else if (clr)
            hold_cnt <= '0;
        else if (run)
            hold_cnt <= expired ? '0 : hold_cnt + 1'b1;
    end

endmodule

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: drives an up/down counter back and forth between two limits with a dwell at each end
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int                WIDTH       = 8,
    parameter logic [WIDTH-1:0]  LOW_LIM     = WIDTH'(2),
    parameter logic [WIDTH-1:0]  HIGH_LIM    = WIDTH'(5),
    parameter int                HOLD_CYCLES = 3,
    parameter int unsigned       NUM_SWEEPS  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] counter_in,
    output logic             enable,
    output logic             direction,
    output logic             busy,
    output logic             sweep_done
);

    // the counter registers enable on the same edge the FSM turns, so turn one step early
    localparam logic [WIDTH-1:0] HI_TURN = HIGH_LIM - 1'b1;
    localparam logic [WIDTH-1:0] LO_TURN = LOW_LIM + 1'b1;
    localparam logic [15:0]      LAST_SWEEP = 16'(NUM_SWEEPS - 1);

    state_t      state;
    logic [15:0] sweep_cnt;
    logic        in_hold;
    logic        hold_exp;

    assign in_hold = (state == HOLD_TOP) || (state == HOLD_BOT);

    sweep_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .clr     (stop || !in_hold),
        .run     (in_hold),
        .expired (hold_exp)
    );

    // sweep sequencer; stop aborts to IDLE from any state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sweep_cnt <= '0;
        end else if (stop) begin
            state     <= IDLE;
            sweep_cnt <= '0;
        end else begin
            case (state)
                IDLE:     if (start) state <= UP;
                UP:       if (counter_in >= HI_TURN) state <= HOLD_TOP;
                HOLD_TOP: if (hold_exp) state <= DOWN;
                DOWN:     if (counter_in <= LO_TURN) state <= HOLD_BOT;
                HOLD_BOT: begin
                    if (hold_exp) begin
                        if (NUM_SWEEPS != 0 && sweep_cnt == LAST_SWEEP) begin
                            state     <= DONE;
                            sweep_cnt <= '0;
                        end else begin
                            state     <= UP;
                            sweep_cnt <= sweep_cnt + 1'b1;
                        end
                    end
                end
                DONE:     state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // limit-gated enable keeps the counter from overshooting even when it starts out of range
    always_comb begin
        enable    = !stop && (((state == UP) && (counter_in < HIGH_LIM)) ||
                              ((state == DOWN) && (counter_in > LOW_LIM)));
        direction = ((state == HOLD_TOP) || (state == DOWN)) ? DIR_DOWN : DIR_UP;
        busy      = is_busy(state);
        sweep_done = (state == DONE);
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: directed bench for sweep_ctrl driving a behavioural 8-bit up/down counter
module tb_sweep_ctrl;

    logic       clk, rst, crst;
    logic       start, stop, start2, stop2;
    logic       preset;
    logic [7:0] preset_val;
    logic [7:0] cnt1, cnt2;
    logic       en1, dir1, busy1, done1;
    logic       en2, dir2, busy2, done2;
    int         checks = 0;
    int         errors = 0;

    sweep_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .counter_in(cnt1),
        .enable(en1), .direction(dir1), .busy(busy1), .sweep_done(done1)
    );

    sweep_ctrl #(.NUM_SWEEPS(0)) dut_cont (
        .clk(clk), .rst(rst), .start(start2), .stop(stop2), .counter_in(cnt2),
        .enable(en2), .direction(dir2), .busy(busy2), .sweep_done(done2)
    );

    // counter models with their own reset
    always_ff @(posedge clk or posedge crst) begin
        if (crst) cnt1 <= 8'd0;
        else if (preset) cnt1 <= preset_val;
        else if (en1) cnt1 <= dir1 ? cnt1 + 8'd1 : cnt1 - 8'd1;
    end

    always_ff @(posedge clk or posedge crst) begin
        if (crst) cnt2 <= 8'd0;
        else if (en2) cnt2 <= dir2 ? cnt2 + 8'd1 : cnt2 - 8'd1;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       start;
        logic       stop;
        logic [7:0] cnt;
        logic       en;
        logic       dir;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic s, logic p, logic [7:0] c, logic e, logic d, logic b, logic dn);
        vec_t r;
        r.start = s; r.stop = p; r.cnt = c; r.en = e; r.dir = d; r.busy = b; r.done = dn;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int first, bad, tops, bots, dn;
        logic [7:0] prev;

        rst = 1'b1; crst = 1'b1; start = 0; stop = 0; start2 = 0; stop2 = 0;
        preset = 0; preset_val = 8'd0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0; crst = 1'b0;
        #1;
        check("reset_enable", en1, 1'b0);
        check("reset_direction", dir1, 1'b1);
        check("reset_busy", busy1, 1'b0);
        check("reset_done", done1, 1'b0);

        // full two-sweep run from counter 0
        vecs.push_back(v(1,0,0,0,1,0,0));
        for (int i = 0; i < 5; i++) vecs.push_back(v(0,0,8'(i),1,1,1,0));
        for (int i = 0; i < 3; i++) vecs.push_back(v(0,0,5,0,0,1,0));
        for (int i = 5; i > 2; i--) vecs.push_back(v(0,0,8'(i),1,0,1,0));
        for (int i = 0; i < 3; i++) vecs.push_back(v(0,0,2,0,1,1,0));
        for (int i = 2; i < 5; i++) vecs.push_back(v(0,0,8'(i),1,1,1,0));
        for (int i = 0; i < 3; i++) vecs.push_back(v(0,0,5,0,0,1,0));
        for (int i = 5; i > 2; i--) vecs.push_back(v(0,0,8'(i),1,0,1,0));
        for (int i = 0; i < 3; i++) vecs.push_back(v(0,0,2,0,1,1,0));
        vecs.push_back(v(0,0,2,0,1,0,1));
        vecs.push_back(v(0,0,2,0,1,0,0));
        // stop at counter 4 in UP
        vecs.push_back(v(1,0,2,0,1,0,0));
        vecs.push_back(v(0,0,2,1,1,1,0));
        vecs.push_back(v(0,0,3,1,1,1,0));
        vecs.push_back(v(0,1,4,0,1,1,0));
        vecs.push_back(v(0,0,4,0,1,0,0));
        vecs.push_back(v(0,0,4,0,1,0,0));
        // start and stop together in IDLE
        vecs.push_back(v(1,1,4,0,1,0,0));
        vecs.push_back(v(0,0,4,0,1,0,0));
        vecs.push_back(v(0,0,4,0,1,0,0));

        foreach (vecs[i]) begin
            @(negedge clk);
            start = vecs[i].start;
            stop  = vecs[i].stop;
            #1;
            check($sformatf("vec%0d cnt/en/dir/busy/done", i),
                  {20'd0, cnt1, en1, dir1, busy1, done1},
                  {20'd0, vecs[i].cnt, vecs[i].en, vecs[i].dir, vecs[i].busy, vecs[i].done});
        end
        start = 0; stop = 0;

        // asynchronous reset mid-cycle while enable is high
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        check("pre_reset_enable", en1, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_enable", en1, 1'b0);
        check("async_rst_busy", busy1, 1'b0);
        check("async_rst_direction", dir1, 1'b1);
        check("async_rst_done", done1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("counter_kept_after_rst", cnt1, 8'd4);

        // counter preset above HIGH_LIM
        @(negedge clk);
        preset = 1'b1; preset_val = 8'd200;
        @(negedge clk);
        preset = 1'b0;
        #1;
        check("preset_value", cnt1, 8'd200);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("oor_up_enable", en1, 1'b0);
        first = -1; bad = 0; prev = cnt1;
        for (int i = 1; i < 260 && first < 0; i++) begin
            @(negedge clk);
            #1;
            if (cnt1 > prev) bad++;
            if (en1 && ((dir1 && cnt1 >= 8'd5) || (!dir1 && cnt1 <= 8'd2))) bad++;
            if (cnt1 == 8'd2) first = i;
            prev = cnt1;
        end
        check("oor_cycles_to_low", first, 202);
        check("oor_no_increase_or_wrap", bad, 0);
        check("oor_at_low_busy", busy1, 1'b1);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        #1;
        check("oor_stopped_busy", busy1, 1'b0);

        // continuous mode
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        tops = 0; bots = 0; bad = 0; dn = 0; prev = 8'd0;
        for (int i = 0; i < 70; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (done2) dn++;
            if (en2 && ((dir2 && cnt2 >= 8'd5) || (!dir2 && cnt2 <= 8'd2))) bad++;
            if (cnt2 == 8'd5 && prev == 8'd4) tops++;
            if (cnt2 == 8'd2 && prev == 8'd3) bots++;
            prev = cnt2;
        end
        check("cont_tops", tops, 6);
        check("cont_bottoms", bots, 5);
        check("cont_no_done", dn, 0);
        check("cont_limit_enable", bad, 0);
        check("cont_busy", busy2, 1'b1);
        @(negedge clk);
        stop2 = 1'b1;
        #1;
        check("cont_stop_enable", en2, 1'b0);
        @(negedge clk);
        stop2 = 1'b0;
        #1;
        check("cont_stopped_busy", busy2, 1'b0);
        check("cont_frozen_count", cnt2, 8'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
